// File: rtl/multiword_alu_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer and the
// 16-bit arithmetic unit it drives.
//   WORD_W      : width of one arithmetic-unit word
//   OP_*        : arithmetic-unit opcodes (shared with the arithmetic unit)
//   state_t     : sequencer control states
package multiword_alu_sequencer_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADC  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/multiword_alu_sequencer.sv
// Multi-precision add/subtract sequencer. Splits two WORDS x 16-bit operands
// into words and feeds them least-significant first to a 16-bit arithmetic
// unit, chaining carries through the unit's registered carry flag.
// Ports:
//   iClock, iReset            : clock, asynchronous active-low reset
//   iValid/oReady             : request handshake (iSub, iOpA, iOpB sampled at accept)
//   oValid/iReady             : result handshake (oResult, oCarryBorrow, oZero)
//   oPortA/oPortB/oOpcode     : registered drive to the arithmetic unit
//   iAccumulator/iCarryflag   : arithmetic unit result and registered carry flag
module multiword_alu_sequencer
  import multiword_alu_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic                      iSub,
  input  logic [WORDS*WORD_W-1:0]   iOpA,
  input  logic [WORDS*WORD_W-1:0]   iOpB,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [WORDS*WORD_W-1:0]   oResult,
  output logic                      oCarryBorrow,
  output logic                      oZero,
  output logic [WORD_W-1:0]         oPortA,
  output logic [WORD_W-1:0]         oPortB,
  output logic [1:0]                oOpcode,
  input  logic [WORD_W-1:0]         iAccumulator,
  input  logic                      iCarryflag
);

  localparam int unsigned W  = WORDS * WORD_W;
  localparam int unsigned KW = $clog2(WORDS);

  state_t          state, state_next;
  logic [W-1:0]    op_a, op_b;
  logic            sub_mode;
  logic [KW-1:0]   k, k_next;
  logic            last_word;
  logic [WORD_W-1:0] a_next, b_next;

  assign k_next    = k + KW'(1);
  assign last_word = (k == KW'(WORDS - 1));
  assign oReady    = (state == S_IDLE);
  assign oValid    = (state == S_DONE);

  // Port registers are loaded one edge ahead of the word they carry, so the
  // arithmetic unit sees word k for the whole RUN cycle in which k is current.
  always_comb begin
    a_next = op_a[32'(k_next)*WORD_W +: WORD_W];
    b_next = op_b[32'(k_next)*WORD_W +: WORD_W];
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (iValid) state_next = iSub ? S_PRIME : S_RUN;
      S_PRIME: state_next = S_RUN;
      S_RUN:   if (last_word) state_next = S_FIN;
      S_FIN:   state_next = S_DONE;
      S_DONE:  if (iReady) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      op_a         <= '0;
      op_b         <= '0;
      sub_mode     <= 1'b0;
      k            <= '0;
      oResult      <= '0;
      oCarryBorrow <= 1'b0;
      oZero        <= 1'b0;
      oPortA       <= '0;
      oPortB       <= '0;
      oOpcode      <= OP_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (iValid) begin
            op_a     <= iOpA;
            op_b     <= iOpB;
            sub_mode <= iSub;
            k        <= '0;
            oOpcode  <= OP_ADD;
            if (iSub) begin
              // FFFF + 0001 leaves the carry flag set: the +1 of two's complement
              oPortA <= '1;
              oPortB <= 16'h0001;
            end else begin
              oPortA <= iOpA[WORD_W-1:0];
              oPortB <= iOpB[WORD_W-1:0];
            end
          end
        end
        S_PRIME: begin
          oPortA  <= op_a[WORD_W-1:0];
          oPortB  <= ~op_b[WORD_W-1:0];
          oOpcode <= OP_ADC;
        end
        S_RUN: begin
          oResult[32'(k)*WORD_W +: WORD_W] <= iAccumulator;
          if (last_word) begin
            oPortA  <= '0;
            oPortB  <= '0;
            oOpcode <= OP_IDLE;
          end else begin
            k       <= k_next;
            oPortA  <= a_next;
            oPortB  <= sub_mode ? ~b_next : b_next;
            oOpcode <= OP_ADC;
          end
        end
        S_FIN: begin
          oCarryBorrow <= sub_mode ? ~iCarryflag : iCarryflag;
          oZero        <= ~|oResult;
        end
        default: ;
      endcase
    end
  end

endmodule
